// File: rtl/snn_mem_pkg.sv
// Shared constants and state encoding for the SNN DFF-RAM burst controller.
package snn_mem_pkg;

    localparam int unsigned MEM_AW     = 8;
    localparam int unsigned MEM_DW     = 32;
    localparam int unsigned MEM_NBYTES = MEM_DW / 8;
    localparam int unsigned MEM_LENW   = 9;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } state_e;

endpackage

// File: rtl/ram_rd_fifo.sv
// Small synchronous FIFO holding read-return words; count_o reports occupancy.
module ram_rd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [DW-1:0]              data_i,
    input  logic                       pop_i,
    output logic [DW-1:0]              head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PW'(1);
            if (do_pop)  rptr_q <= rptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: only slots below count_q are ever observed.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/dffram_burst_ctrl.sv
// Burst initiator for a 256x32 DFF RAM macro: streamed writes, credit-limited
// reads buffered in a small FIFO because the macro zeroes Do0 when EN0 is low.
module dffram_burst_ctrl
    import snn_mem_pkg::*;
#(
    parameter int unsigned AW            = MEM_AW,
    parameter int unsigned DW            = MEM_DW,
    parameter int unsigned LENW          = MEM_LENW,
    parameter int unsigned RD_FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [LENW-1:0]   cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DW-1:0]     wr_data,
    input  logic [DW/8-1:0]   wr_be,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DW-1:0]     rd_data,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic [DW/8-1:0]   ram_we,
    output logic [AW-1:0]     ram_a,
    output logic [DW-1:0]     ram_di,
    input  logic [DW-1:0]     ram_do
);

    localparam int unsigned CW = $clog2(RD_FIFO_DEPTH) + 1;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [LENW-1:0] iss_q, iss_d;
    logic [LENW-1:0] pop_q, pop_d;
    logic            infl_q;

    logic [CW-1:0]   fifo_count;
    logic [DW-1:0]   fifo_head;
    logic            wr_beat, rd_issue, rd_pop;

    assign wr_beat  = (state_q == WRITE) && wr_valid;
    // Credit: words already buffered plus the one in flight must leave room.
    assign rd_issue = (state_q == READ) && (iss_q != '0) &&
                      ((fifo_count + CW'(infl_q)) < CW'(RD_FIFO_DEPTH));
    assign rd_valid = (fifo_count != '0);
    assign rd_pop   = rd_valid && rd_ready;
    assign rd_data  = rd_valid ? fifo_head : '0;

    ram_rd_fifo #(
        .DEPTH (RD_FIFO_DEPTH),
        .DW    (DW)
    ) u_rd_fifo (
        .clk_i   (CLK),
        .rst_ni  (RSTN),
        .push_i  (infl_q),
        .data_i  (ram_do),
        .pop_i   (rd_pop),
        .head_o  (fifo_head),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        iss_d   = iss_q;
        pop_d   = pop_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    iss_d  = cmd_len;
                    pop_d  = cmd_len;
                    if (cmd_len == '0)  state_d = DONE;
                    else if (cmd_write) state_d = WRITE;
                    else                state_d = READ;
                end
            end
            WRITE: begin
                if (wr_beat) begin
                    addr_d = addr_q + AW'(1);
                    iss_d  = iss_q - LENW'(1);
                    if (iss_q == LENW'(1)) state_d = DONE;
                end
            end
            READ: begin
                if (rd_issue) begin
                    addr_d = addr_q + AW'(1);
                    iss_d  = iss_q - LENW'(1);
                end
                if (rd_pop) begin
                    pop_d = pop_q - LENW'(1);
                    if (pop_q == LENW'(1)) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            addr_q  <= '0;
            iss_q   <= '0;
            pop_q   <= '0;
            infl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            iss_q   <= iss_d;
            pop_q   <= pop_d;
            infl_q  <= rd_issue;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign wr_ready  = (state_q == WRITE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign ram_en    = wr_beat || rd_issue;
    assign ram_we    = wr_beat ? wr_be : '0;
    assign ram_a     = ram_en ? addr_q : '0;
    assign ram_di    = wr_beat ? wr_data : '0;

endmodule

// File: tb/tb_dffram_burst_ctrl.sv
// Directed plus randomized bench for dffram_burst_ctrl against a RAM macro model
// and a word-level reference memory with a credit/latency view of the read stream.
module tb_dffram_burst_ctrl;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int NB    = DW / 8;
    localparam int LENW  = 9;
    localparam int DEPTH = 4;

    logic            CLK = 1'b0;
    logic            RSTN = 1'b0;
    logic            cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0]   cmd_addr = '0;
    logic [LENW-1:0] cmd_len = '0;
    logic            wr_valid = 1'b0, wr_ready;
    logic [DW-1:0]   wr_data = '0;
    logic [NB-1:0]   wr_be = '0;
    logic            rd_valid, rd_ready = 1'b0;
    logic [DW-1:0]   rd_data;
    logic            busy, done;
    logic            ram_en;
    logic [NB-1:0]   ram_we;
    logic [AW-1:0]   ram_a;
    logic [DW-1:0]   ram_di;
    logic [DW-1:0]   ram_do = '0;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] macro_mem [256];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] wq [$];
    logic [NB-1:0] bq [$];

    dffram_burst_ctrl #(
        .AW            (AW),
        .DW            (DW),
        .LENW          (LENW),
        .RD_FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_a     (ram_a),
        .ram_di    (ram_di),
        .ram_do    (ram_do)
    );

    always #5 CLK = ~CLK;

    // Macro: registered read, output forced to zero when not enabled.
    always @(posedge CLK) begin
        if (ram_en) begin
            ram_do <= macro_mem[ram_a];
            for (int b = 0; b < NB; b++)
                if (ram_we[b]) macro_mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
        end else begin
            ram_do <= '0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [LENW-1:0] n);
        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = n;
        #1;
        chk("cmd_ready", cmd_ready, 1);
        chk("cmd_idle_en", ram_en, 0);
    endtask

    task automatic finish_checks(input string tag);
        @(negedge CLK);
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        rd_ready  = 1'b0;
        #1;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_done_busy"}, busy, 1);
        chk({tag, "_done_cmdrdy"}, cmd_ready, 0);
        chk({tag, "_done_en"}, ram_en, 0);
        @(negedge CLK);
        #1;
        chk({tag, "_post_done"}, done, 0);
        chk({tag, "_post_busy"}, busy, 0);
        chk({tag, "_post_cmdrdy"}, cmd_ready, 1);
    endtask

    // Writes wq/bq starting at a; gaps inserts random idle cycles on wr_valid.
    task automatic do_write(input logic [AW-1:0] a, input bit gaps);
        int  n = wq.size();
        int  i = 0;
        logic v;
        send_cmd(1'b1, a, LENW'(n));
        while (i < n) begin
            @(negedge CLK);
            cmd_valid = 1'b0;
            v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            wr_valid = v;
            wr_data  = wq[i];
            wr_be    = bq[i];
            #1;
            chk("wr_ready", wr_ready, 1);
            chk("wr_busy", busy, 1);
            chk("wr_done_early", done, 0);
            chk("wr_en", ram_en, v);
            if (v) begin
                chk("wr_we", ram_we, bq[i]);
                chk("wr_a", ram_a, AW'(a + i));
                chk("wr_di", ram_di, wq[i]);
                for (int b = 0; b < NB; b++)
                    if (bq[i][b]) ref_mem[AW'(a + i)][8*b +: 8] = wq[i][8*b +: 8];
                i++;
            end else begin
                chk("wr_idle_we", ram_we, 0);
            end
        end
        finish_checks("wr");
    endtask

    // Reads n words from a; rd_ready low for the first hold cycles, then 1 or random.
    task automatic do_read(input logic [AW-1:0] a, input int n, input int hold, input bit rnd);
        int   issued = 0;
        int   popped = 0;
        int   t = 0;
        int   avail;
        int   itime [$];
        logic rdy, exp_en, exp_v;
        send_cmd(1'b0, a, LENW'(n));
        while (popped < n && t < 3000) begin
            @(negedge CLK);
            cmd_valid = 1'b0;
            rdy = (t < hold) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            rd_ready = rdy;
            #1;
            exp_en = (issued < n) && ((issued - popped) < DEPTH);
            chk("rd_en", ram_en, exp_en);
            chk("rd_we", ram_we, 0);
            chk("rd_busy", busy, 1);
            chk("rd_done_early", done, 0);
            if (exp_en) begin
                chk("rd_a", ram_a, AW'(a + issued));
                itime.push_back(t);
                issued++;
            end
            avail = 0;
            foreach (itime[k]) if (itime[k] <= t - 2) avail++;
            exp_v = (avail > popped);
            chk("rd_valid", rd_valid, exp_v);
            if (exp_v) begin
                chk("rd_data", rd_data, ref_mem[AW'(a + popped)]);
                if (rdy) popped++;
            end else begin
                chk("rd_data_idle", rd_data, 0);
            end
            t++;
        end
        chk("rd_all_popped", popped, n);
        finish_checks("rd");
    endtask

    task automatic load_q(input int n, input bit rnd_be);
        wq.delete();
        bq.delete();
        for (int i = 0; i < n; i++) begin
            wq.push_back($urandom);
            bq.push_back(rnd_be ? NB'($urandom_range(0, 15)) : '1);
        end
    endtask

    initial begin
        logic [AW-1:0] a;
        int            n;

        // Reset values
        #12;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_a", ram_a, 0);
        chk("rst_ram_di", ram_di, 0);
        @(negedge CLK);
        RSTN = 1'b1;

        // Fill the whole macro with a maximum-length burst (also wraps at 0xFF)
        load_q(256, 1'b0);
        do_write(8'h37, 1'b0);

        // Write A0..A3 at 0x10 and read back
        wq.delete();
        bq.delete();
        for (int i = 0; i < 4; i++) begin
            wq.push_back(32'h0000_00A0 + i);
            bq.push_back(4'hF);
        end
        do_write(8'h10, 1'b0);
        do_read(8'h10, 4, 0, 1'b0);

        // Wrap around the top of the address space
        load_q(3, 1'b0);
        do_write(8'hFE, 1'b0);
        do_read(8'hFE, 3, 0, 1'b0);

        // Backpressure: rd_ready low for six cycles
        do_read(8'h40, 8, 6, 1'b0);

        // Zero-length commands, both directions
        wq.delete();
        bq.delete();
        do_write(8'h20, 1'b0);
        do_read(8'h20, 0, 0, 1'b0);

        // Partial byte enables
        wq.delete();
        bq.delete();
        wq.push_back(32'h1122_3344);
        bq.push_back(4'h5);
        do_write(8'h80, 1'b0);
        do_read(8'h80, 1, 0, 1'b0);

        // Randomized mix
        for (int r = 0; r < 10; r++) begin
            a = AW'($urandom);
            n = $urandom_range(1, 20);
            if ($urandom_range(0, 1) == 1) begin
                load_q(n, 1'b1);
                do_write(a, 1'b1);
            end else begin
                do_read(a, n, $urandom_range(0, 5), 1'b1);
            end
        end
        do_read(8'h00, 256, 0, 1'b1);

        // Reset in the middle of a long read
        send_cmd(1'b0, 8'h90, 16);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            cmd_valid = 1'b0;
            rd_ready  = 1'b0;
        end
        @(negedge CLK);
        #1;
        chk("mid_rd_valid", rd_valid, 1);
        RSTN = 1'b0;
        #1;
        chk("rst_mid_rd_valid", rd_valid, 0);
        chk("rst_mid_ram_en", ram_en, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        @(negedge CLK);
        RSTN = 1'b1;
        #1;
        chk("rel_cmd_ready", cmd_ready, 1);
        chk("rel_busy", busy, 0);
        do_read(8'h95, 1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
